// File: rtl/ibex_instr_trace_sched.sv
// ID-stage trace capture FIFO with hysteresis drop mode and drop accounting.
// Define IBEX_TRACE_COMPRESSED_EN to store and emit the raw compressed encoding.
module ibex_instr_trace_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  valid_id_i,
  input  logic                  stall_id_i,
  input  logic                  err_id_i,
  input  logic                  is_compressed_id_i,
  input  logic [15:0]           instr_compressed_id_i,
  input  logic [DATA_WIDTH-1:0] instr_id_i,
  input  logic [DATA_WIDTH-1:0] pc_id_i,
  input  logic                  branch_taken_id_i,
  input  logic [DATA_WIDTH-1:0] branch_target_id_i,
  input  logic                  jump_set_id_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_instr_o,
  output logic [15:0]           out_instr_c_o,
  output logic [DATA_WIDTH-1:0] out_target_o,
  output logic [3:0]            out_flags_o,
  output logic [CNT_WIDTH-1:0]  dropped_cnt_o,
  output logic                  overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] HALF = PW'(DEPTH / 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DROP,
    FLUSH
  } state_e;

  state_e                state_q;
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [PW-1:0]         occ;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] pc_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] ins_mem [DEPTH];
  logic [DATA_WIDTH-1:0] tgt_mem [DEPTH];
  logic [3:0]            flg_mem [DEPTH];

  logic          full;
  logic          empty;
  logic          ev;
  logic          pop;
  logic          push;
  logic          drop;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  assign occ   = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = rptr_q[AW-1:0];
  assign tail  = wptr_q[AW-1:0];

  assign ev   = enable_i & valid_id_i & ~stall_id_i & ~flush_i &
                ((state_q == RUN) | (state_q == DROP));
  assign pop  = out_valid_o & out_ready_i;
  // A full FIFO still accepts in RUN when the head leaves the same cycle.
  assign push = ev & (state_q == RUN) & (~full | pop);
  assign drop = ev & ~push;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= FLUSH;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      case (state_q)
        IDLE: if (enable_i) state_q <= RUN;
        RUN: begin
          if (!enable_i) state_q <= IDLE;
          else if (drop) state_q <= DROP;
        end
        DROP: begin
          if (!enable_i) state_q <= IDLE;
          else if (occ <= HALF) state_q <= RUN;
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[tail]  <= pc_id_i;
      ins_mem[tail] <= instr_id_i;
      tgt_mem[tail] <= branch_target_id_i;
      flg_mem[tail] <= {jump_set_id_i, branch_taken_id_i,
                        is_compressed_id_i, err_id_i};
    end
  end

  assign out_valid_o   = ~empty;
  assign out_pc_o      = out_valid_o ? pc_mem[head]  : '0;
  assign out_instr_o   = out_valid_o ? ins_mem[head] : '0;
  assign out_target_o  = out_valid_o ? tgt_mem[head] : '0;
  assign out_flags_o   = out_valid_o ? flg_mem[head] : '0;
  assign dropped_cnt_o = cnt_q;
  assign overflow_o    = ovf_q;

`ifdef IBEX_TRACE_COMPRESSED_EN
  logic [15:0] ic_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (push) ic_mem[tail] <= instr_compressed_id_i;
  end

  assign out_instr_c_o = out_valid_o ? ic_mem[head] : '0;
`else
  logic unused_instr_c;

  assign unused_instr_c = ^instr_compressed_id_i;
  assign out_instr_c_o  = '0;
`endif

endmodule

// File: tb/tb_ibex_instr_trace_sched.sv
// Scoreboard bench for ibex_instr_trace_sched: directed events, decoupled
// output monitor comparing each handshake against queued expectations.
module tb_ibex_instr_trace_sched;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] tgt;
    logic [15:0] ic;
    logic [3:0]  fl;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic        flush_i;
  logic        valid_id_i;
  logic        stall_id_i;
  logic        err_id_i;
  logic        is_compressed_id_i;
  logic [15:0] instr_compressed_id_i;
  logic [31:0] instr_id_i;
  logic [31:0] pc_id_i;
  logic        branch_taken_id_i;
  logic [31:0] branch_target_id_i;
  logic        jump_set_id_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic [15:0] out_instr_c_o;
  logic [31:0] out_target_o;
  logic [3:0]  out_flags_o;
  logic [15:0] dropped_cnt_o;
  logic        overflow_o;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];

  ibex_instr_trace_sched dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .enable_i              (enable_i),
    .flush_i               (flush_i),
    .valid_id_i            (valid_id_i),
    .stall_id_i            (stall_id_i),
    .err_id_i              (err_id_i),
    .is_compressed_id_i    (is_compressed_id_i),
    .instr_compressed_id_i (instr_compressed_id_i),
    .instr_id_i            (instr_id_i),
    .pc_id_i               (pc_id_i),
    .branch_taken_id_i     (branch_taken_id_i),
    .branch_target_id_i    (branch_target_id_i),
    .jump_set_id_i         (jump_set_id_i),
    .out_valid_o           (out_valid_o),
    .out_ready_i           (out_ready_i),
    .out_pc_o              (out_pc_o),
    .out_instr_o           (out_instr_o),
    .out_instr_c_o         (out_instr_c_o),
    .out_target_o          (out_target_o),
    .out_flags_o           (out_flags_o),
    .dropped_cnt_o         (dropped_cnt_o),
    .overflow_o            (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    ent_t e;
    ent_t a;
    if (rst_ni && out_valid_o && out_ready_i) begin
      a = {out_pc_o, out_instr_o, out_target_o, out_instr_c_o, out_flags_o};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got %h, expected no entry", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL out_entry: got %h, expected %h", a, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] tgt, input logic [15:0] ic,
                              input logic [3:0] fl);
    ent_t e;
    e.pc  = pc;
    e.ins = ins;
    e.tgt = tgt;
    e.ic  = ic;
    e.fl  = fl;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    pc_id_i               = e.pc;
    instr_id_i            = e.ins;
    branch_target_id_i    = e.tgt;
    instr_compressed_id_i = e.ic;
    jump_set_id_i         = e.fl[3];
    branch_taken_id_i     = e.fl[2];
    is_compressed_id_i    = e.fl[1];
    err_id_i              = e.fl[0];
  endtask

  task automatic expect_push(input ent_t e);
    ent_t x;
    x = e;
`ifndef IBEX_TRACE_COMPRESSED_EN
    x.ic = 16'h0;
`endif
    sb.push_back(x);
  endtask

  // One-cycle event; cap says whether it must reach the output.
  task automatic ev(input ent_t e, input bit cap);
    drive(e);
    valid_id_i = 1'b1;
    if (cap) expect_push(e);
    tick();
    valid_id_i = 1'b0;
  endtask

  function automatic ent_t seq(input int i);
    return mk(32'h8000_1000 + 32'(i * 4), 32'h0010_0093 + 32'(i << 20),
              32'h0, 16'h0, 4'b0000);
  endfunction

  initial begin
    ent_t br;
    ent_t ej;
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    flush_i     = 1'b0;
    valid_id_i  = 1'b0;
    stall_id_i  = 1'b0;
    out_ready_i = 1'b0;
    drive(mk(32'h0, 32'h0, 32'h0, 16'h0, 4'h0));
    tick();
    tick();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_pc", 64'(out_pc_o), 64'd0);
    chk("rst_instr", 64'(out_instr_o), 64'd0);
    chk("rst_instr_c", 64'(out_instr_c_o), 64'd0);
    chk("rst_target", 64'(out_target_o), 64'd0);
    chk("rst_flags", 64'(out_flags_o), 64'd0);
    chk("rst_cnt", 64'(dropped_cnt_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rst_ni   = 1'b1;
    enable_i = 1'b1;
    tick();

    // single event, one-cycle latency
    out_ready_i = 1'b1;
    ev(mk(32'h8000_0000, 32'h0000_0013, 32'h0, 16'h0, 4'h0), 1'b1);
    chk("lat_valid", 64'(out_valid_o), 64'd1);
    chk("lat_pc", 64'(out_pc_o), 64'h8000_0000);
    chk("lat_flags", 64'(out_flags_o), 64'd0);
    tick();
    chk("lat_one_cycle", 64'(out_valid_o), 64'd0);

    // stalled instruction captured once
    drive(seq(50));
    valid_id_i = 1'b1;
    stall_id_i = 1'b1;
    tick();
    tick();
    stall_id_i = 1'b0;
    expect_push(seq(50));
    tick();
    valid_id_i = 1'b0;
    tick();
    tick();
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // back-pressure: 6 events into depth 4
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) ev(seq(i), i < 4);
    chk("bp_cnt", 64'(dropped_cnt_o), 64'd2);
    chk("bp_ovf", 64'(overflow_o), 64'd1);
    chk("bp_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    tick();
    ev(seq(6), 1'b0);
    out_ready_i = 1'b0;
    chk("drop_mode_cnt", 64'(dropped_cnt_o), 64'd3);
    tick();
    ev(seq(7), 1'b1);
    chk("resume_cnt", 64'(dropped_cnt_o), 64'd3);

    // full FIFO, push and pop together
    ev(seq(8), 1'b1);
    out_ready_i = 1'b1;
    ev(seq(9), 1'b1);
    out_ready_i = 1'b0;
    chk("fullpp_cnt", 64'(dropped_cnt_o), 64'd3);
    ev(seq(10), 1'b0);
    ev(seq(11), 1'b0);
    chk("fullpp_occ4_cnt", 64'(dropped_cnt_o), 64'd5);
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready_i = 1'b0;
    chk("drain_valid", 64'(out_valid_o), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // flush with 3 queued and 5 drops
    for (int i = 20; i < 23; i++) ev(seq(i), 1'b1);
    chk("pre_flush_valid", 64'(out_valid_o), 64'd1);
    chk("pre_flush_cnt", 64'(dropped_cnt_o), 64'd5);
    sb.delete();
    flush_i = 1'b1;
    ev(seq(30), 1'b0);
    flush_i = 1'b0;
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_cnt", 64'(dropped_cnt_o), 64'd0);
    chk("flush_ovf", 64'(overflow_o), 64'd0);
    out_ready_i = 1'b1;
    ev(seq(31), 1'b0);
    ev(seq(32), 1'b0);
    tick();
    chk("post_flush_valid", 64'(out_valid_o), 64'd0);

    // taken branch from compressed c.j
    br = mk(32'h8000_0000, 32'h1000_006F, 32'h8000_0100, 16'hA201, 4'b0110);
    ev(br, 1'b1);
    chk("br_flags", 64'(out_flags_o), 64'b0110);
    chk("br_target", 64'(out_target_o), 64'h8000_0100);
`ifdef IBEX_TRACE_COMPRESSED_EN
    chk("br_instr_c", 64'(out_instr_c_o), 64'hA201);
`else
    chk("br_instr_c", 64'(out_instr_c_o), 64'h0);
`endif
    tick();

    ej = mk(32'h8000_0200, 32'h0040_006F, 32'h8000_0204, 16'h0, 4'b1001);
    ev(ej, 1'b1);
    chk("ej_flags", 64'(out_flags_o), 64'b1001);
    tick();

    // disabled: no capture
    enable_i = 1'b0;
    tick();
    ev(seq(40), 1'b0);
    tick();
    chk("disabled_valid", 64'(out_valid_o), 64'd0);
    enable_i = 1'b1;
    tick();

    // asynchronous reset mid-cycle
    out_ready_i = 1'b0;
    for (int i = 60; i < 65; i++) ev(seq(i), 1'b0);
    chk("prerst_cnt", 64'(dropped_cnt_o), 64'd1);
    chk("prerst_valid", 64'(out_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_cnt", 64'(dropped_cnt_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_pc", 64'(out_pc_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("final_sb", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
